// File: rtl/mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq
// Purpose  : Sequential strided dot-product engine. It reads two operand
//            vectors from a Data_Bank with asynchronous reads, accumulates
//            their full-precision signed products, then writes back a
//            rounded (round-half-up), saturated fixed-point result.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            start                - job request pulse (sampled in IDLE only)
//            a_base/b_base        - first operand addresses
//            a_stride/b_stride    - address increment per element
//            len                  - element count (0..2^LENW-1)
//            dst_addr             - result address
//            raddr_a/raddr_b      - Data_Bank read addresses (valid in ACC)
//            rdata_a/rdata_b      - Data_Bank read data (same cycle)
//            we/waddr/wdata       - Data_Bank write port (valid in WRITE)
//            busy, done, ovf      - status: in progress, completion pulse,
//                                   sticky saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq #(
  parameter int W     = 24,
  parameter int ADDRW = 5,
  parameter int FRAC  = 12,
  parameter int LENW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] a_base,
  input  logic [ADDRW-1:0] b_base,
  input  logic [ADDRW-1:0] a_stride,
  input  logic [ADDRW-1:0] b_stride,
  input  logic [LENW-1:0]  len,
  input  logic [ADDRW-1:0] dst_addr,
  output logic [ADDRW-1:0] raddr_a,
  output logic [ADDRW-1:0] raddr_b,
  input  logic [W-1:0]     rdata_a,
  input  logic [W-1:0]     rdata_b,
  output logic             we,
  output logic [ADDRW-1:0] waddr,
  output logic [W-1:0]     wdata,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  // Accumulator headroom: one product is 2W bits; LENW extra bits cover up
  // to 2^LENW-1 additions, plus one guard bit so the rounding add can never
  // wrap.
  localparam int C_AW = 2*W + LENW + 1;

  localparam logic [C_AW-1:0] C_RND     = C_AW'(1) << (FRAC-1);
  localparam logic [C_AW-1:0] C_MAX_EXT = {{(C_AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [C_AW-1:0] C_MIN_EXT = {{(C_AW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic [W-1:0]    C_MAX     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]    C_MIN     = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Address registers walk base + i*stride incrementally; the natural
  // ADDRW-bit wrap gives the required mod 2^ADDRW behaviour with no multiply.
  logic [ADDRW-1:0]       addr_a_q, addr_b_q;
  logic [ADDRW-1:0]       stride_a_q, stride_b_q;
  logic [ADDRW-1:0]       dst_q;
  logic [LENW-1:0]        len_q, i_q;
  logic signed [C_AW-1:0] acc_q;
  logic                   ovf_q;

  logic signed [2*W-1:0]  w_prod;
  logic signed [C_AW-1:0] w_prod_ext;
  logic signed [C_AW-1:0] w_rnd_sum;
  logic signed [C_AW-1:0] w_rnd;
  logic                   w_over, w_under;
  logic [W-1:0]           w_result;
  logic                   w_last;

  assign w_prod     = $signed(rdata_a) * $signed(rdata_b);
  assign w_prod_ext = {{(C_AW-2*W){w_prod[2*W-1]}}, w_prod};

  // Round half up: add half an LSB of the output format, then floor-shift.
  assign w_rnd_sum  = acc_q + $signed(C_RND);
  assign w_rnd      = w_rnd_sum >>> FRAC;
  assign w_over     = w_rnd > $signed(C_MAX_EXT);
  assign w_under    = w_rnd < $signed(C_MIN_EXT);
  assign w_result   = w_over  ? C_MAX :
                      w_under ? C_MIN : w_rnd[W-1:0];

  // In ACC len_q is never zero, so len_q-1 does not underflow.
  assign w_last     = (i_q == (len_q - LENW'(1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? ACC : WRITE;
      ACC:     if (w_last) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state only, so start never reaches
  // we/done combinationally.
  always_comb begin
    busy    = 1'b0;
    raddr_a = '0;
    raddr_b = '0;
    we      = 1'b0;
    done    = 1'b0;
    waddr   = '0;
    wdata   = '0;
    unique case (state_q)
      ACC: begin
        busy    = 1'b1;
        raddr_a = addr_a_q;
        raddr_b = addr_b_q;
      end
      WRITE: begin
        busy  = 1'b1;
        we    = 1'b1;
        done  = 1'b1;
        waddr = dst_q;
        wdata = w_result;
      end
      default: ;
    endcase
  end

  assign ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      stride_a_q <= '0;
      stride_b_q <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            addr_a_q   <= a_base;
            addr_b_q   <= b_base;
            stride_a_q <= a_stride;
            stride_b_q <= b_stride;
            dst_q      <= dst_addr;
            len_q      <= len;
            i_q        <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
          end
        end
        ACC: begin
          acc_q    <= acc_q + w_prod_ext;
          i_q      <= i_q + LENW'(1);
          addr_a_q <= addr_a_q + stride_a_q;
          addr_b_q <= addr_b_q + stride_b_q;
        end
        WRITE: begin
          if (w_over || w_under) ovf_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq
// Purpose  : Self-checking bench for mac_seq. Jobs push their expected write
//            (address, data, ovf, cycle) into a queue; a negedge monitor pops
//            and compares whenever the DUT writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq;

  localparam int W     = 24;
  localparam int ADDRW = 5;
  localparam int FRAC  = 12;
  localparam int LENW  = 3;
  localparam int DEPTH = 1 << ADDRW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDRW-1:0] a_base, b_base, a_stride, b_stride, dst_addr;
  logic [LENW-1:0]  len;
  logic [ADDRW-1:0] raddr_a, raddr_b, waddr;
  logic [W-1:0]     rdata_a, rdata_b, wdata;
  logic             we, busy, done, ovf;

  logic signed [W-1:0] mem [DEPTH];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always #5 clk = ~clk;

  mac_seq #(.W(W), .ADDRW(ADDRW), .FRAC(FRAC), .LENW(LENW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_base   (a_base),
    .b_base   (b_base),
    .a_stride (a_stride),
    .b_stride (b_stride),
    .len      (len),
    .dst_addr (dst_addr),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     addr;
    longint data;
    bit     ovf;
    int     cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: direct index arithmetic with multiply, then round/saturate.
  task automatic model(input int ab, input int bb, input int as, input int bs,
                       input int ln, output longint res, output bit ov);
    longint acc = 0;
    longint r;
    longint maxv = (64'sd1 <<< (W-1)) - 1;
    longint minv = -(64'sd1 <<< (W-1));
    for (int k = 0; k < ln; k++) begin
      acc += longint'(mem[(ab + k*as) % DEPTH]) * longint'(mem[(bb + k*bs) % DEPTH]);
    end
    r  = (acc + (64'sd1 <<< (FRAC-1))) >>> FRAC;
    ov = (r > maxv) || (r < minv);
    res = (r > maxv) ? maxv : (r < minv) ? minv : r;
  endtask

  // Monitor: every we/done must match a queued expectation; ovf is checked
  // one cycle after the write, when the sticky flag has been updated.
  bit   ovf_pend = 1'b0;
  logic ovf_exp;
  always @(negedge clk) begin
    exp_t e;
    if (ovf_pend) begin
      chk("ovf_after_write", ovf, ovf_exp);
      ovf_pend = 1'b0;
    end
    if (we || done) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {we, done}, 0);
      end else begin
        e = q.pop_front();
        chk("waddr",   waddr,          e.addr);
        chk("wdata",   $signed(wdata), e.data);
        chk("we_done", {we, done},     3);
        chk("latency", cyc,            e.cyc);
        ovf_pend = 1'b1;
        ovf_exp  = e.ovf;
      end
    end
  end

  // mode 0: no expectation, 1: model, 2: literal (ldata, lovf).
  // Returns at the negedge of cycle 1 with job inputs scrambled.
  task automatic issue(input int ab, input int bb, input int as, input int bs,
                       input int ln, input int dst, input int mode,
                       input longint ldata = 0, input bit lovf = 1'b0);
    longint res;
    bit     ov;
    @(negedge clk);
    a_base   = ADDRW'(ab);
    b_base   = ADDRW'(bb);
    a_stride = ADDRW'(as);
    b_stride = ADDRW'(bs);
    len      = LENW'(ln);
    dst_addr = ADDRW'(dst);
    start    = 1'b1;
    if (mode == 1) begin
      model(ab, bb, as, bs, ln, res, ov);
      q.push_back('{dst, res, ov, cyc + ln + 1});
    end else if (mode == 2) begin
      q.push_back('{dst, ldata, lovf, cyc + ln + 1});
    end
    @(negedge clk);
    start    = 1'b0;
    a_base   = ADDRW'($urandom);
    b_base   = ADDRW'($urandom);
    a_stride = ADDRW'($urandom);
    b_stride = ADDRW'($urandom);
    len      = LENW'($urandom);
    dst_addr = ADDRW'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || busy) && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    a_base = '0; b_base = '0; a_stride = '0; b_stride = '0;
    len = '0; dst_addr = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy,    0);
    chk("rst_done",  done,    0);
    chk("rst_we",    we,      0);
    chk("rst_ovf",   ovf,     0);
    chk("rst_raddr", {raddr_a, raddr_b}, 0);
    chk("rst_waddr", waddr,   0);
    chk("rst_wdata", wdata,   0);
    rst = 1'b0;

    // 1.0 * 2.0 in Q12
    mem[0] = 24'sd4096; mem[1] = 24'sd8192;
    issue(0, 1, 1, 1, 1, 5, 2, 8192, 0);
    chk("busy_in_acc", busy, 1);
    wait_idle();

    // 1*1 + 1*(-1) + 1*0.5 = 0.5
    mem[0] = 24'sd4096; mem[1] = 24'sd4096; mem[2] = 24'sd4096;
    mem[8] = 24'sd4096; mem[9] = -24'sd4096; mem[10] = 24'sd2048;
    issue(0, 8, 1, 1, 3, 7, 2, 2048, 0);
    wait_idle();

    // Positive saturation; ovf must stay set while idle
    mem[3] = 24'sh7FFFFF;
    issue(3, 3, 0, 0, 1, 9, 2, 64'sh7FFFFF, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ovf_sticky", ovf, 1);

    // Address wrap: a_base=31, stride 1; also ovf cleared by the new start
    mem[31] = 24'sd300; mem[0] = -24'sd5000; mem[2] = 24'sd7000; mem[3] = 24'sd123;
    issue(31, 2, 1, 1, 2, 11, 1);
    chk("ovf_clear", ovf, 0);
    chk("raddr_a_c1", raddr_a, 31);
    chk("raddr_b_c1", raddr_b, 2);
    @(negedge clk);
    chk("raddr_a_c2", raddr_a, 0);
    chk("raddr_b_c2", raddr_b, 3);
    wait_idle();

    // len=0 writes zero in cycle 1; a start during WRITE is ignored
    issue(4, 5, 1, 1, 0, 12, 2, 0, 0);
    start = 1'b1;
    len   = LENW'(3);
    @(negedge clk);
    start = 1'b0;
    chk("len0_ignored_start", busy, 0);
    repeat (6) @(negedge clk);
    chk("len0_still_idle", busy, 0);

    // Random jobs, including negative saturation candidates and wrap
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
      if (j == 2) begin
        mem[20] = 24'sh800000; mem[21] = 24'sh7FFFFF;
      end
      if (j == 2) issue(20, 21, 0, 0, 7, 1, 1);
      else issue(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 (j == 0) ? 7 : int'($urandom_range(1, 7)),
                 int'($urandom_range(0, 31)), 1);
      wait_idle();
    end

    // Reset mid-job: no write, no done afterwards
    issue(0, 1, 1, 1, 5, 3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_we",   we,   0);
    chk("rst_mid_ovf",  ovf,  0);
    repeat (12) @(negedge clk);
    chk("rst_mid_idle", busy, 0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
